// File: rtl/alu_issue_stage_if.sv
// Bundle of ID-side, forwarding and ALU-side signals for the execute-issue stage.
// The master side drives the instruction, forwarding, flush and out_ready; the slave is the stage.
interface alu_issue_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       shamt_in;
    logic [15:0]      imm16;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             exm_we;
    logic [4:0]       exm_addr;
    logic [WIDTH-1:0] exm_data;
    logic             mwb_we;
    logic [4:0]       mwb_addr;
    logic [WIDTH-1:0] mwb_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_f;
    logic [4:0]       alu_shamt;
    logic [WIDTH-1:0] store_data;
    logic             illegal;

    modport master (
        output in_valid, opcode, funct, shamt_in, imm16, rs_addr, rt_addr,
               rs_data, rt_data, exm_we, exm_addr, exm_data, mwb_we, mwb_addr,
               mwb_data, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_f, alu_shamt, store_data,
               illegal
    );

    modport slave (
        input  in_valid, opcode, funct, shamt_in, imm16, rs_addr, rt_addr,
               rs_data, rt_data, exm_we, exm_addr, exm_data, mwb_we, mwb_addr,
               mwb_data, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_f, alu_shamt, store_data,
               illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Execute-issue stage: operand forwarding, operand-B select and ALU function decode,
// registered into a single valid/ready slot consumed combinationally by the ALU.
module alu_issue_stage #(
    parameter int unsigned WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    alu_issue_stage_if.slave bus
);
    localparam int unsigned IMM_W = 16;
    localparam logic [3:0] F_AND = 4'b0000;
    localparam logic [3:0] F_OR  = 4'b0001;
    localparam logic [3:0] F_ADD = 4'b0010;
    localparam logic [3:0] F_SLL = 4'b0100;
    localparam logic [3:0] F_SRL = 4'b0101;
    localparam logic [3:0] F_SUB = 4'b1010;
    localparam logic [3:0] F_SLT = 4'b1011;

    logic             valid_q;
    logic [WIDTH-1:0] a_q, b_q, sd_q;
    logic [3:0]       f_q;
    logic [4:0]       sh_q;
    logic             ill_q;

    logic             xfer;
    logic [WIDTH-1:0] fwd_a, fwd_b, imm_se, imm_ze;
    logic [WIDTH-1:0] a_nxt, b_nxt;
    logic [3:0]       f_nxt;
    logic [4:0]       sh_nxt;
    logic             ill_nxt;

    // EX/MEM has priority over MEM/WB; register 0 always reads as zero
    function automatic logic [WIDTH-1:0] fwd(
        input logic [4:0]       addr,
        input logic [WIDTH-1:0] rf,
        input logic             e_we,
        input logic [4:0]       e_addr,
        input logic [WIDTH-1:0] e_data,
        input logic             m_we,
        input logic [4:0]       m_addr,
        input logic [WIDTH-1:0] m_data
    );
        if (addr == 5'd0)                  return '0;
        else if (e_we && (e_addr == addr)) return e_data;
        else if (m_we && (m_addr == addr)) return m_data;
        else                               return rf;
    endfunction

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign xfer         = bus.in_valid && bus.in_ready;

    assign fwd_a  = fwd(bus.rs_addr, bus.rs_data, bus.exm_we, bus.exm_addr, bus.exm_data,
                        bus.mwb_we, bus.mwb_addr, bus.mwb_data);
    assign fwd_b  = fwd(bus.rt_addr, bus.rt_data, bus.exm_we, bus.exm_addr, bus.exm_data,
                        bus.mwb_we, bus.mwb_addr, bus.mwb_data);
    assign imm_se = {{(WIDTH-IMM_W){bus.imm16[IMM_W-1]}}, bus.imm16};
    assign imm_ze = {{(WIDTH-IMM_W){1'b0}}, bus.imm16};

    // Decode into next slot contents
    always_comb begin
        a_nxt   = fwd_a;
        b_nxt   = fwd_b;
        f_nxt   = F_AND;
        sh_nxt  = 5'd0;
        ill_nxt = 1'b0;
        case (bus.opcode)
            6'h00: begin
                case (bus.funct)
                    6'h20, 6'h21: f_nxt = F_ADD;
                    6'h22, 6'h23: f_nxt = F_SUB;
                    6'h24:        f_nxt = F_AND;
                    6'h25:        f_nxt = F_OR;
                    6'h2A:        f_nxt = F_SLT;
                    6'h00: begin
                        f_nxt  = F_SLL;
                        sh_nxt = bus.shamt_in;
                        a_nxt  = '0;
                    end
                    6'h02: begin
                        f_nxt  = F_SRL;
                        sh_nxt = bus.shamt_in;
                        a_nxt  = '0;
                    end
                    default: ill_nxt = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin f_nxt = F_ADD; b_nxt = imm_se; end
            6'h0A:        begin f_nxt = F_SLT; b_nxt = imm_se; end
            6'h0C:        begin f_nxt = F_AND; b_nxt = imm_ze; end
            6'h0D:        begin f_nxt = F_OR;  b_nxt = imm_ze; end
            6'h23, 6'h2B: begin f_nxt = F_ADD; b_nxt = imm_se; end
            6'h04:        f_nxt = F_SUB;
            default:      ill_nxt = 1'b1;
        endcase
        // Unsupported encodings still occupy the slot but present a zeroed ALU op
        if (ill_nxt) begin
            a_nxt  = '0;
            b_nxt  = '0;
            f_nxt  = F_AND;
            sh_nxt = 5'd0;
        end
    end

    // Pipeline slot; flush outranks both load and clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sd_q    <= '0;
            f_q     <= F_AND;
            sh_q    <= 5'd0;
            ill_q   <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (xfer) begin
            valid_q <= 1'b1;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            sd_q    <= fwd_b;
            f_q     <= f_nxt;
            sh_q    <= sh_nxt;
            ill_q   <= ill_nxt;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.store_data = sd_q;
    assign bus.alu_f      = f_q;
    assign bus.alu_shamt  = sh_q;
    assign bus.illegal    = ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a table-driven reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_alu_issue_stage;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_issue_stage_if #(.WIDTH(32)) bus ();
    alu_issue_stage #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Decode tables: -1 = unsupported. I-type B source: 0 = rt, 1 = sign-ext, 2 = zero-ext.
    int r_code [64];
    int i_code [64];
    int i_bsrc [64];

    // Reference slot contents
    bit          m_valid = 1'b0;
    logic [31:0] m_a, m_b, m_sd;
    logic [3:0]  m_f;
    logic [4:0]  m_sh;
    logic        m_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] rf);
        if (addr == 0) return 32'd0;
        if (bus.exm_we && bus.exm_addr == addr) return bus.exm_data;
        if (bus.mwb_we && bus.mwb_addr == addr) return bus.mwb_data;
        return rf;
    endfunction

    task automatic ref_load();
        logic [31:0] fa, fb;
        int code, src;
        bit shift;
        fa = ref_fwd(bus.rs_addr, bus.rs_data);
        fb = ref_fwd(bus.rt_addr, bus.rt_data);
        m_sd = fb;
        shift = 1'b0;
        if (bus.opcode == 6'd0) begin
            code  = r_code[bus.funct];
            shift = (bus.funct == 6'h00) || (bus.funct == 6'h02);
            m_a   = shift ? 32'd0 : fa;
            m_b   = fb;
        end else begin
            code = i_code[bus.opcode];
            src  = i_bsrc[bus.opcode];
            m_a  = fa;
            m_b  = (src == 1) ? {{16{bus.imm16[15]}}, bus.imm16} :
                   (src == 2) ? {16'd0, bus.imm16} : fb;
        end
        m_sh = shift ? bus.shamt_in : 5'd0;
        if (code < 0) begin
            m_ill = 1'b1; m_a = 0; m_b = 0; m_f = 0; m_sh = 0;
        end else begin
            m_ill = 1'b0; m_f = 4'(code);
        end
    endtask

    // Reference model of the slot occupancy
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
        end else if (bus.flush) begin
            m_valid = 1'b0;
        end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
            ref_load();
            m_valid = 1'b1;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
            chk("cyc_out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("cyc_alu_a", bus.alu_a, m_a);
                chk("cyc_alu_b", bus.alu_b, m_b);
                chk("cyc_alu_f", 32'(bus.alu_f), 32'(m_f));
                chk("cyc_shamt", 32'(bus.alu_shamt), 32'(m_sh));
                chk("cyc_store", bus.store_data, m_sd);
                chk("cyc_illegal", 32'(bus.illegal), 32'(m_ill));
            end
        end
    end

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                             input logic [15:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [31:0] rsd, input logic [31:0] rtd);
        bus.opcode = op; bus.funct = fn; bus.shamt_in = sh; bus.imm16 = imm;
        bus.rs_addr = rs; bus.rt_addr = rt; bus.rs_data = rsd; bus.rt_data = rtd;
        bus.in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsd, input logic [31:0] rtd);
        set_instr(op, fn, sh, imm, rs, rt, rsd, rtd);
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin r_code[i] = -1; i_code[i] = -1; i_bsrc[i] = 0; end
        r_code['h20] = 2; r_code['h21] = 2; r_code['h22] = 10; r_code['h23] = 10;
        r_code['h24] = 0; r_code['h25] = 1; r_code['h2A] = 11; r_code['h00] = 4; r_code['h02] = 5;
        i_code['h08] = 2;  i_bsrc['h08] = 1; i_code['h09] = 2; i_bsrc['h09] = 1;
        i_code['h0A] = 11; i_bsrc['h0A] = 1; i_code['h0C] = 0; i_bsrc['h0C] = 2;
        i_code['h0D] = 1;  i_bsrc['h0D] = 2; i_code['h23] = 2; i_bsrc['h23] = 1;
        i_code['h2B] = 2;  i_bsrc['h2B] = 1; i_code['h04] = 10;
    end

    initial begin
        bus.in_valid = 0; bus.opcode = 0; bus.funct = 0; bus.shamt_in = 0; bus.imm16 = 0;
        bus.rs_addr = 0; bus.rt_addr = 0; bus.rs_data = 0; bus.rt_data = 0;
        bus.exm_we = 0; bus.exm_addr = 0; bus.exm_data = 0;
        bus.mwb_we = 0; bus.mwb_addr = 0; bus.mwb_data = 0;
        bus.flush = 0; bus.out_ready = 1;

        repeat (3) step();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_alu_f", 32'(bus.alu_f), 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_store", bus.store_data, 0);
        chk("rst_shamt", 32'(bus.alu_shamt), 0);
        chk("rst_illegal", 32'(bus.illegal), 0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        // add $3,$1,$2
        send(6'h00, 6'h20, 0, 16'h0000, 1, 2, 32'd5, 32'd7);
        chk("add_valid", 32'(bus.out_valid), 1);
        chk("add_a", bus.alu_a, 5);
        chk("add_b", bus.alu_b, 7);
        chk("add_f", 32'(bus.alu_f), 32'b0010);

        send(6'h08, 6'h00, 0, 16'hFFFF, 1, 2, 32'd5, 32'd7);
        chk("addi_b_se", bus.alu_b, 32'hFFFF_FFFF);
        send(6'h0C, 6'h00, 0, 16'hFFFF, 1, 2, 32'd5, 32'd7);
        chk("andi_b_ze", bus.alu_b, 32'h0000_FFFF);
        chk("andi_f", 32'(bus.alu_f), 0);

        // Forwarding priority
        bus.exm_we = 1; bus.exm_addr = 4; bus.exm_data = 32'h11;
        bus.mwb_we = 1; bus.mwb_addr = 4; bus.mwb_data = 32'h22;
        send(6'h00, 6'h20, 0, 0, 4, 4, 32'h33, 32'h44);
        chk("fwd_exm_a", bus.alu_a, 32'h11);
        chk("fwd_exm_b", bus.alu_b, 32'h11);
        chk("fwd_exm_sd", bus.store_data, 32'h11);
        bus.exm_we = 0;
        send(6'h00, 6'h20, 0, 0, 4, 4, 32'h33, 32'h44);
        chk("fwd_mwb_a", bus.alu_a, 32'h22);
        chk("fwd_mwb_b", bus.alu_b, 32'h22);
        bus.exm_we = 1; bus.exm_addr = 0; bus.exm_data = 32'h99;
        send(6'h00, 6'h20, 0, 0, 0, 4, 32'h55, 32'h44);
        chk("fwd_r0_a", bus.alu_a, 0);
        bus.exm_we = 0; bus.mwb_we = 0;

        // Remaining opcodes/functs through the model
        send(6'h00, 6'h23, 0, 0, 1, 2, 32'd9, 32'd3);
        send(6'h00, 6'h25, 0, 0, 1, 2, 32'hF0, 32'h0F);
        send(6'h00, 6'h2A, 0, 0, 1, 2, 32'd1, 32'd2);
        chk("slt_f", 32'(bus.alu_f), 32'b1011);
        send(6'h0A, 0, 0, 16'h8000, 1, 2, 32'd1, 32'd2);
        send(6'h0D, 0, 0, 16'h8001, 1, 2, 32'd1, 32'd2);
        send(6'h23, 0, 0, 16'h0010, 1, 2, 32'h100, 32'hAB);
        send(6'h2B, 0, 0, 16'hFFF0, 1, 2, 32'h100, 32'hAB);
        chk("sw_store", bus.store_data, 32'hAB);
        send(6'h04, 0, 0, 16'h0003, 1, 2, 32'd6, 32'd6);
        chk("beq_f", 32'(bus.alu_f), 32'b1010);
        chk("beq_b", bus.alu_b, 6);

        // Shifts and illegal encodings
        send(6'h00, 6'h00, 5'd3, 0, 7, 2, 32'd99, 32'd1);
        chk("sll_f", 32'(bus.alu_f), 32'b0100);
        chk("sll_shamt", 32'(bus.alu_shamt), 3);
        chk("sll_b", bus.alu_b, 1);
        chk("sll_a", bus.alu_a, 0);
        send(6'h00, 6'h02, 5'd31, 0, 7, 2, 32'd99, 32'h8000_0000);
        chk("srl_f", 32'(bus.alu_f), 32'b0101);
        send(6'h3F, 6'h20, 5'd4, 16'h1234, 1, 2, 32'd5, 32'd7);
        chk("ill_flag", 32'(bus.illegal), 1);
        chk("ill_f", 32'(bus.alu_f), 0);
        chk("ill_valid", 32'(bus.out_valid), 1);
        chk("ill_a", bus.alu_a, 0);
        send(6'h00, 6'h08, 5'd4, 0, 1, 2, 32'd5, 32'd7);
        chk("ill_rfunct", 32'(bus.illegal), 1);
        send(6'h00, 6'h20, 5'd4, 0, 1, 2, 32'd5, 32'd7);
        chk("add_shamt0", 32'(bus.alu_shamt), 0);
        step();
        chk("slot_clear", 32'(bus.out_valid), 0);

        // Backpressure: slot held, then reload on the releasing edge
        bus.out_ready = 0;
        send(6'h00, 6'h20, 0, 0, 1, 2, 32'd5, 32'd7);
        set_instr(6'h00, 6'h22, 0, 0, 1, 2, 32'd9, 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            step();
            chk("bp_hold_a", bus.alu_a, 5);
            chk("bp_hold_f", 32'(bus.alu_f), 32'b0010);
        end
        bus.out_ready = 1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 0;
        chk("bp_new_a", bus.alu_a, 9);
        chk("bp_new_f", 32'(bus.alu_f), 32'b1010);
        chk("bp_new_valid", 32'(bus.out_valid), 1);

        // Flush while stalled with an incoming instruction
        bus.out_ready = 0;
        send(6'h00, 6'h20, 0, 0, 1, 2, 32'd5, 32'd7);
        set_instr(6'h00, 6'h24, 0, 0, 1, 2, 32'd1, 32'd1);
        bus.flush = 1;
        step();
        bus.flush = 0; bus.in_valid = 0;
        chk("flush_valid", 32'(bus.out_valid), 0);
        // Flush with an open slot also drops the transfer
        bus.out_ready = 1;
        set_instr(6'h00, 6'h24, 0, 0, 1, 2, 32'd1, 32'd1);
        bus.flush = 1;
        step();
        bus.flush = 0; bus.in_valid = 0;
        chk("flush_drop", 32'(bus.out_valid), 0);

        // Asynchronous reset during a stall
        bus.out_ready = 0;
        send(6'h00, 6'h20, 0, 0, 1, 2, 32'd5, 32'd7);
        chk("pre_rst_valid", 32'(bus.out_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 0);
        chk("async_rst_a", bus.alu_a, 0);
        chk("async_rst_ready", 32'(bus.in_ready), 1);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1;
        send(6'h09, 0, 0, 16'h0001, 1, 2, 32'd41, 32'd0);
        chk("post_rst_a", bus.alu_a, 41);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
